nabu_bus_responder: RTL and testbench
=====================================

# nabu_bus_responder

Read-side companion to the NABU control/ISR capture registers: answers Z80 I/O reads and interrupt-acknowledge cycles on the shared data bus. It snapshots trap status into readable registers and drives the interrupt request line. It also supplies the interrupt vector during the acknowledge cycle. It sits between the MegaMapper trap logic and the Z80 bus, and samples the bus strobes with a fast local clock.

## Interface
- `IO_BASE`, 8'h40: I/O base address. Bits [7:2] are decoded; bits [1:0] select the register.
- `VECTOR`, 8'hE8: byte driven during interrupt acknowledge.
- `clk`  in  1  local clock, ≥ 25 MHz.
- `reset`  in  1  asynchronous, active-high.
- `addr`  in  8  Z80 A[7:0].
- `rd_n`, `iorq_n`, `m1_n`  in  1 each  raw Z80 strobes, asynchronous to `clk`.
- `ctrl_reg`  in  8  control byte from the write-side register block; bit0 is the interrupt enable.
- `trap_event`  in  1  one-`clk` pulse when a trap occurs.
- `trap_addr`  in  16  trapped address, valid with `trap_event`.
- `data_out`  out  8  read data toward the bus transceiver.
- `data_oe`  out  1  drive enable for `data_out`.
- `int_n`  out  1  Z80 /INT, active low.

One clock; reset is asynchronous and active-high.

## Operation
- **Strobe sampling:** `rd_n`, `iorq_n` and `m1_n` each pass through a 2-flop synchronizer. Decoding uses only the synchronized copies. `addr` is sampled in the same cycle the state machine leaves IDLE.
- **Register map (offset from IO_BASE):**
  - 0: status. {6'b0, overflow, pending}.
  - 1: trap address [7:0].
  - 2: trap address [15:8].
  - 3: `ctrl_reg` readback.
- **State machine:**
  - IDLE → IORD when the synchronized `iorq_n`=0, `rd_n`=0, `m1_n`=1 and addr[7:2] matches. `data_out` is loaded with the selected register and `data_oe` goes to 1.
  - IDLE → INTA when the synchronized `iorq_n`=0 and `m1_n`=0. `data_out` is loaded with VECTOR and `data_oe` goes to 1.
  - An I/O read with an address mismatch stays in IDLE with `data_oe`=0.
  - IORD/INTA → RELEASE when the synchronized `iorq_n` returns to 1. `data_oe` goes to 0 and side effects are applied.
  - RELEASE → IDLE unconditionally on the next cycle.
- **Read side effects, applied at RELEASE:**
  - Reading offset 2 clears `pending`.
  - Reading offset 0 clears `overflow`.
  - INTA has no side effect on `pending`.
- **Trap capture:**
  - `trap_event` with `pending`=0: set `pending` and load the trap address.
  - `trap_event` with `pending`=1: set `overflow`; the trap address is not overwritten.
- **Interrupt:** `int_n` = ~(`pending` & `ctrl_reg[0]`), registered.
- **Data stability:** `data_out` is a snapshot taken at state entry. It is held stable for the whole cycle even if a trap arrives mid-read.

## Timing
- **Reset values:** `data_oe`=0, `data_out`=8'h00, `int_n`=1, `pending`=0, `overflow`=0, trap address 16'h0000, state IDLE.
- **Reset mid-cycle:** `data_oe` drops asynchronously and the FSM returns to IDLE. No side effect is applied.
- **Drive latency:** `data_oe` rises 3 `clk` edges after the later of the qualifying strobe falls (2 sync + 1 register). It falls 3 edges after `iorq_n` rises.
- **`int_n` latency:** 1 `clk` after `pending` or `ctrl_reg[0]` changes.
- **Simultaneous events:**
  - `trap_event` in the same cycle as the RELEASE that clears `pending`: the new trap wins. `pending` stays 1, the address updates, `overflow` is unchanged.
  - `trap_event` in the same cycle as the RELEASE that clears `overflow`, with `pending`=1: `overflow` stays 1.
- **Back-to-back reads:** each read requires a return through IDLE, so there are at least 2 `clk` with `iorq_n` high between reads. This is always true at Z80 rates.

## Structure
- Shared package holds:
  - register offset constants (STATUS=0, TADDR_LO=1, TADDR_HI=2, CTRL=3);
  - the FSM state encoding (IDLE, IORD, INTA, RELEASE).
- Sub-module `sync2`: a 2-flop synchronizer with a reset value parameter, defaulting to 1. It is instantiated once per strobe.

## Test plan
- **Reset:** assert `reset` during an active read → `data_oe`=0 immediately, `int_n`=1; after release, status reads 8'h00.
- **Trap and read:** pulse `trap_event` with `trap_addr`=16'hBEEF and `ctrl_reg`=8'h01 → `int_n`=0 after 1 cycle. Reads at 8'h41/8'h42 return 8'hEF/8'hBE. After the 8'h42 cycle ends, `int_n`=1.
- **Interrupt acknowledge:** `m1_n`=0 with `iorq_n`=0 → `data_out`=8'hE8 and `data_oe`=1 within 3 clk. `pending` is unchanged.
- **Overflow:** two traps (16'h1234 then 16'h5678) with no read → status=8'h03 and the address reads 16'h1234. A status read, then another status read, returns 8'h01.
- **Collision:** `trap_event` (16'hAAAA) in the RELEASE cycle of an offset-2 read → `pending` stays 1, the address reads 16'hAAAA, `overflow`=0.
- **Decode miss:** a read at 8'h44 and 8'h3F → `data_oe` stays 0. With `ctrl_reg[0]`=0, `int_n` stays 1 despite a pending trap.

Source files
------------

// File: rtl/nabu_bus_responder_pkg.sv
// Shared definitions for the NABU bus responder: register offsets, FSM states
// and the read-data mux used when a read cycle is entered.
package nabu_bus_responder_pkg;

  localparam logic [7:0] IO_BASE = 8'h40;
  localparam logic [7:0] VECTOR  = 8'hE8;

  localparam logic [1:0] STATUS   = 2'd0;
  localparam logic [1:0] TADDR_LO = 2'd1;
  localparam logic [1:0] TADDR_HI = 2'd2;
  localparam logic [1:0] CTRL     = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IORD    = 2'd1,
    INTA    = 2'd2,
    RELEASE = 2'd3
  } state_e;

  function automatic logic [7:0] reg_mux(
    input logic [1:0]  off,
    input logic        pend,
    input logic        ovf,
    input logic [15:0] taddr,
    input logic [7:0]  ctrl
  );
    logic [7:0] val;
    case (off)
      STATUS:   val = {6'b0, ovf, pend};
      TADDR_LO: val = taddr[7:0];
      TADDR_HI: val = taddr[15:8];
      default:  val = ctrl;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/nabu_bus_responder_sync2.sv
// Two-flop synchronizer for one asynchronous Z80 strobe; resets to RST_VAL so
// an idle (high) strobe does not look active coming out of reset.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/nabu_bus_responder.sv
// Answers Z80 I/O reads and interrupt acknowledges from the trap status
// registers; captures trap events and drives /INT.
//   state   | meaning
//   IDLE    | bus not addressed, data_oe low
//   IORD    | I/O read of our block, snapshot driven
//   INTA    | interrupt acknowledge, VECTOR driven
//   RELEASE | strobe gone, read side effects applied
module nabu_bus_responder
  import nabu_bus_responder_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  addr,
  input  logic        rd_n,
  input  logic        iorq_n,
  input  logic        m1_n,
  input  logic [7:0]  ctrl_reg,
  input  logic        trap_event,
  input  logic [15:0] trap_addr,
  output logic [7:0]  data_out,
  output logic        data_oe,
  output logic        int_n
);

  logic rd_s, iorq_s, m1_s;

  sync2 #(.RST_VAL(1'b1)) u_sync_rd   (.clk(clk), .reset(reset), .d_i(rd_n),   .q_o(rd_s));
  sync2 #(.RST_VAL(1'b1)) u_sync_iorq (.clk(clk), .reset(reset), .d_i(iorq_n), .q_o(iorq_s));
  sync2 #(.RST_VAL(1'b1)) u_sync_m1   (.clk(clk), .reset(reset), .d_i(m1_n),   .q_o(m1_s));

  state_e      state_q;
  logic [1:0]  sel_q;
  logic        was_iord_q;
  logic [7:0]  data_out_q;
  logic        data_oe_q;
  logic        int_n_q;
  logic        pending_q, pending_d;
  logic        overflow_q, overflow_d;
  logic [15:0] taddr_q, taddr_d;

  logic       io_hit;
  logic [7:0] rd_val;
  logic       clr_pend, clr_ovf, pend_keep, ovf_keep;

  assign io_hit = !iorq_s && !rd_s && m1_s && (addr[7:2] == IO_BASE[7:2]);
  assign rd_val = reg_mux(addr[1:0], pending_q, overflow_q, taddr_q, ctrl_reg);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      sel_q      <= STATUS;
      was_iord_q <= 1'b0;
      data_out_q <= 8'h00;
      data_oe_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!iorq_s && !m1_s) begin
            state_q    <= INTA;
            was_iord_q <= 1'b0;
            data_out_q <= VECTOR;
            data_oe_q  <= 1'b1;
          end else if (io_hit) begin
            state_q    <= IORD;
            was_iord_q <= 1'b1;
            sel_q      <= addr[1:0];
            data_out_q <= rd_val;
            data_oe_q  <= 1'b1;
          end
        end
        IORD, INTA: begin
          if (iorq_s) begin
            state_q   <= RELEASE;
            data_oe_q <= 1'b0;
          end
        end
        RELEASE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // A trap landing on the release edge wins over the clear it coincides with.
  always_comb begin
    clr_pend   = (state_q == RELEASE) && was_iord_q && (sel_q == TADDR_HI);
    clr_ovf    = (state_q == RELEASE) && was_iord_q && (sel_q == STATUS);
    pend_keep  = pending_q && !clr_pend;
    ovf_keep   = overflow_q && !clr_ovf;
    pending_d  = pend_keep;
    overflow_d = ovf_keep;
    taddr_d    = taddr_q;
    if (trap_event) begin
      if (pend_keep) begin
        overflow_d = 1'b1;
      end else begin
        pending_d = 1'b1;
        taddr_d   = trap_addr;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q  <= 1'b0;
      overflow_q <= 1'b0;
      taddr_q    <= 16'h0000;
      int_n_q    <= 1'b1;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      taddr_q    <= taddr_d;
      int_n_q    <= !(pending_q && ctrl_reg[0]);
    end
  end

  assign data_out = data_out_q;
  assign data_oe  = data_oe_q;
  assign int_n    = int_n_q;

endmodule

// File: tb/tb_nabu_bus_responder.sv
// Bench for nabu_bus_responder: transaction-level register model, per-cycle
// output compare, directed scenarios followed by randomized traffic.
module tb_nabu_bus_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  addr;
  logic        rd_n, iorq_n, m1_n;
  logic [7:0]  ctrl_reg;
  logic        trap_event;
  logic [15:0] trap_addr;
  logic [7:0]  data_out;
  logic        data_oe;
  logic        int_n;

  always #5 clk = ~clk;

  nabu_bus_responder dut (
    .clk(clk), .reset(reset), .addr(addr), .rd_n(rd_n), .iorq_n(iorq_n),
    .m1_n(m1_n), .ctrl_reg(ctrl_reg), .trap_event(trap_event),
    .trap_addr(trap_addr), .data_out(data_out), .data_oe(data_oe), .int_n(int_n)
  );

  int n_checks = 0;
  int n_fail   = 0;

  bit          m_pend, m_ovf;
  logic [15:0] m_taddr;
  logic        exp_oe, exp_int_n;
  logic [7:0]  exp_data;
  bit          clr_p, clr_o, cap_req, cap_inta;
  logic [1:0]  cap_off;
  bit          chk_en = 1'b0;
  bit          rand_trap_en = 1'b0;
  logic [7:0]  last_rd;
  bit          oe_seen;

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_reg(input logic [1:0] off);
    case (off)
      2'd0:    return {6'b0, m_ovf, m_pend};
      2'd1:    return m_taddr[7:0];
      2'd2:    return m_taddr[15:8];
      default: return ctrl_reg;
    endcase
  endfunction

  task automatic model_reset();
    m_pend = 0; m_ovf = 0; m_taddr = 16'h0000;
    exp_oe = 1'b0; exp_data = 8'h00; exp_int_n = 1'b1;
    clr_p = 0; clr_o = 0; cap_req = 0;
  endtask

  // One clock edge: apply the register rules to whatever the bench drove.
  task automatic tick();
    bit p, o, n_int;
    @(posedge clk);
    if (cap_req) begin
      exp_data = cap_inta ? 8'hE8 : model_reg(cap_off);
      exp_oe   = 1'b1;
      cap_req  = 0;
    end
    n_int = !(m_pend && ctrl_reg[0]);
    p = m_pend && !clr_p;
    o = m_ovf && !clr_o;
    if (trap_event) begin
      if (p) o = 1;
      else begin
        p = 1;
        m_taddr = trap_addr;
      end
    end
    m_pend = p; m_ovf = o; clr_p = 0; clr_o = 0;
    exp_int_n = n_int;
    #1;
    if (rand_trap_en && $urandom_range(0, 7) == 0) begin
      trap_event = 1'b1;
      trap_addr  = 16'($urandom);
    end else begin
      trap_event = 1'b0;
    end
  endtask

  task automatic bus_read(input logic [7:0] a, input bit inta, input int hold,
                          input bit coll, input logic [15:0] coll_addr);
    bit hit;
    hit = inta || (a[7:2] == 6'h10);
    addr = a; iorq_n = 1'b0; rd_n = inta; m1_n = !inta;
    oe_seen = 0;
    tick(); oe_seen |= data_oe;
    tick(); oe_seen |= data_oe;
    cap_req = hit; cap_inta = inta; cap_off = a[1:0];
    tick(); oe_seen |= data_oe;
    last_rd = data_out;
    for (int i = 0; i < hold; i++) begin
      tick(); oe_seen |= data_oe;
    end
    iorq_n = 1'b1; rd_n = 1'b1; m1_n = 1'b1;
    tick(); tick(); tick();
    exp_oe = 1'b0;
    if (hit && !inta) begin
      clr_p = (a[1:0] == 2'd2);
      clr_o = (a[1:0] == 2'd0);
    end
    if (coll) begin
      trap_event = 1'b1;
      trap_addr  = coll_addr;
    end
    tick(); tick();
  endtask

  task automatic trap(input logic [15:0] ta);
    trap_event = 1'b1; trap_addr = ta;
    tick();
  endtask

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      check1("int_n", int_n, exp_int_n);
      check1("data_oe", data_oe, exp_oe);
      if (exp_oe) check8("data_out", data_out, exp_data);
    end
  end

  initial begin
    reset = 1'b1; addr = 8'h00; rd_n = 1'b1; iorq_n = 1'b1; m1_n = 1'b1;
    ctrl_reg = 8'h00; trap_event = 1'b0; trap_addr = 16'h0000;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check1("rst_data_oe", data_oe, 1'b0);
    check1("rst_int_n", int_n, 1'b1);
    check8("rst_data_out", data_out, 8'h00);
    chk_en = 1'b1;

    // trap and read
    ctrl_reg = 8'h01;
    trap(16'hBEEF); tick();
    check1("int_after_trap", int_n, 1'b0);
    bus_read(8'h41, 0, 2, 0, 16'h0); check8("rd_taddr_lo", last_rd, 8'hEF);
    bus_read(8'h42, 0, 1, 0, 16'h0); check8("rd_taddr_hi", last_rd, 8'hBE);
    check1("int_after_clear", int_n, 1'b1);

    // interrupt acknowledge leaves pending alone
    trap(16'h1111);
    bus_read(8'h00, 1, 2, 0, 16'h0); check8("inta_vector", last_rd, 8'hE8);
    bus_read(8'h40, 0, 0, 0, 16'h0); check8("status_after_inta", last_rd, 8'h01);
    bus_read(8'h43, 0, 0, 0, 16'h0); check8("ctrl_readback", last_rd, 8'h01);
    bus_read(8'h42, 0, 0, 0, 16'h0); check8("hi_after_inta", last_rd, 8'h11);

    // overflow
    trap(16'h1234); tick(); trap(16'h5678);
    bus_read(8'h40, 0, 1, 0, 16'h0); check8("ovf_status", last_rd, 8'h03);
    bus_read(8'h40, 0, 1, 0, 16'h0); check8("ovf_status2", last_rd, 8'h01);
    bus_read(8'h41, 0, 1, 0, 16'h0); check8("ovf_lo", last_rd, 8'h34);
    bus_read(8'h42, 0, 1, 0, 16'h0); check8("ovf_hi", last_rd, 8'h12);

    // trap colliding with the pending clear
    trap(16'h1357);
    bus_read(8'h42, 0, 1, 1, 16'hAAAA); check8("coll_hi_old", last_rd, 8'h13);
    bus_read(8'h40, 0, 0, 0, 16'h0); check8("coll_status", last_rd, 8'h01);
    bus_read(8'h41, 0, 0, 0, 16'h0); check8("coll_lo", last_rd, 8'hAA);
    bus_read(8'h42, 0, 0, 0, 16'h0); check8("coll_hi", last_rd, 8'hAA);
    bus_read(8'h40, 0, 0, 0, 16'h0); check8("coll_status_clr", last_rd, 8'h00);

    // trap colliding with the overflow clear
    trap(16'h0102); tick(); trap(16'h0304);
    bus_read(8'h40, 0, 1, 1, 16'h0506); check8("ovfcoll_st1", last_rd, 8'h03);
    bus_read(8'h40, 0, 1, 0, 16'h0); check8("ovfcoll_st2", last_rd, 8'h03);
    bus_read(8'h40, 0, 1, 0, 16'h0); check8("ovfcoll_st3", last_rd, 8'h01);
    bus_read(8'h42, 0, 1, 0, 16'h0); check8("ovfcoll_hi", last_rd, 8'h01);

    // decode miss and masked interrupt
    ctrl_reg = 8'h00;
    trap(16'h2222); tick(); tick();
    check1("masked_int", int_n, 1'b1);
    bus_read(8'h44, 0, 2, 0, 16'h0); check1("miss_44_oe", oe_seen, 1'b0);
    bus_read(8'h3F, 0, 2, 0, 16'h0); check1("miss_3f_oe", oe_seen, 1'b0);
    check1("masked_int2", int_n, 1'b1);
    bus_read(8'h42, 0, 0, 0, 16'h0); check8("miss_hi", last_rd, 8'h22);

    // reset in the middle of a read
    ctrl_reg = 8'h01;
    trap(16'h4242); tick(); tick();
    addr = 8'h43; iorq_n = 1'b0; rd_n = 1'b0; m1_n = 1'b1;
    tick(); tick();
    cap_req = 1; cap_inta = 0; cap_off = 2'd3;
    tick();
    check1("pre_reset_oe", data_oe, 1'b1);
    check1("pre_reset_int", int_n, 1'b0);
    #2 reset = 1'b1;
    #1;
    check1("async_rst_oe", data_oe, 1'b0);
    check1("async_rst_int", int_n, 1'b1);
    check8("async_rst_data", data_out, 8'h00);
    model_reset();
    iorq_n = 1'b1; rd_n = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    bus_read(8'h40, 0, 1, 0, 16'h0); check8("status_after_rst", last_rd, 8'h00);

    // randomized traffic
    rand_trap_en = 1'b1;
    repeat (80) begin
      int r;
      logic [7:0] a;
      r = $urandom_range(0, 9);
      if (r <= 1) begin
        ctrl_reg = 8'($urandom);
        tick();
      end else if (r == 2) begin
        tick();
      end else if (r == 3) begin
        bus_read(8'($urandom), 1, $urandom_range(0, 4), 1'($urandom), 16'($urandom));
      end else begin
        if ($urandom_range(0, 2) == 0) a = 8'($urandom);
        else a = {6'h10, 2'($urandom)};
        bus_read(a, 0, $urandom_range(0, 4), 1'($urandom), 16'($urandom));
      end
    end
    rand_trap_en = 1'b0;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
